pmod_led_arbiter: RTL

Shares one PMOD 8LED2 bicolor LED module (8 green, 8 red lines) among up to N_REQ pattern sources, e.g. the binary counter, the heartbeat and debug monitors. A round-robin arbiter with a minimum-hold timer gives each requester the display for a guaranteed number of ticks. All inputs are stored in registers before they drive the pmodledg/pmodledr pins.

---
 rtl/pmod_led_pkg.sv | 24 ++
 rtl/pmod_led_tick.sv | 27 ++
 rtl/pmod_led_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pmod_led_pkg.sv
// Shared types and helpers for the PMOD 8LED2 arbiter.
// PMOD_LED_ARB_BLANK_EN adds the BLANK state to the encoding.
package pmod_led_pkg;

    localparam int LED_W = 8;

`ifdef PMOD_LED_ARB_BLANK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BLANK = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
    } state_t;
`endif

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pmod_led_tick.sv
// Free-running tick generator: one-cycle pulse every TICK_DIV clocks.
module pmod_led_tick #(
    parameter int TICK_DIV = 12000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pmod_led_arbiter.sv
// Round-robin owner arbitration with minimum hold for one PMOD 8LED2 module.
// Define PMOD_LED_ARB_BLANK_EN to insert a blank period between owners.
module pmod_led_arbiter
    import pmod_led_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TICK_DIV   = 12000,
    parameter int HOLD_TICKS = 500
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [LED_W*N_REQ-1:0] ledg_in,
    input  logic [LED_W*N_REQ-1:0] ledr_in,
    output logic [N_REQ-1:0]       grant,
    output logic [0:7]             pmodledg,
    output logic [0:7]             pmodledr,
    output logic                   busy
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

    logic [1:0]       r_sync;
    logic             w_rst_n;
    logic             w_tick;
    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_owner, w_owner_nxt;
    logic [IDX_W-1:0] r_rr, w_rr_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic [N_REQ-1:0] w_owner_oh;
    logic             w_others;
    logic [IDX_W-1:0] w_after_owner;
    logic [IDX_W:0]   w_pick_rr, w_pick_after;
    logic [LED_W-1:0] w_slice_g, w_slice_r;

    // Assertion is immediate; release reaches the FSM two clocks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_sync[1];

    pmod_led_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(w_rst_n),
        .tick (w_tick)
    );

    // Returns {found, index} of the first set request at or after start.
    function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0] rq,
                                            input logic [IDX_W-1:0] start);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        idx = start;
        for (int k = 0; k < N_REQ; k++) begin
            if (!res[IDX_W] && rq[idx]) begin
                res = {1'b1, idx};
            end
            idx = IDX_W'(rr_next(32'(idx), N_REQ));
        end
        return res;
    endfunction

    assign w_owner_oh    = N_REQ'(1) << r_owner;
    assign w_others      = |(req & ~w_owner_oh);
    assign w_after_owner = IDX_W'(rr_next(32'(r_owner), N_REQ));
    assign w_pick_rr     = pick(req, r_rr);
    assign w_pick_after  = pick(req, w_after_owner);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE: begin
                if (w_pick_rr[IDX_W]) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_pick_rr[IDX_W-1:0];
                    w_hold_nxt  = HOLD_LOAD;
                end
            end
            GRANT: begin
                // Owner drop takes priority over hold expiry.
                if (!req[r_owner] || (r_hold == '0 && w_others)) begin
                    w_rr_nxt = w_after_owner;
                    if (!w_pick_after[IDX_W]) begin
                        w_state_nxt = IDLE;
                    end else begin
`ifdef PMOD_LED_ARB_BLANK_EN
                        w_state_nxt = BLANK;
`else
                        w_state_nxt = GRANT;
`endif
                        w_owner_nxt = w_pick_after[IDX_W-1:0];
                        w_hold_nxt  = HOLD_LOAD;
                    end
                end else if (w_tick && r_hold != '0) begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
`ifdef PMOD_LED_ARB_BLANK_EN
            BLANK: begin
                if (w_tick) begin
                    if (w_pick_rr[IDX_W]) begin
                        w_state_nxt = GRANT;
                        w_owner_nxt = w_pick_rr[IDX_W-1:0];
                        w_hold_nxt  = HOLD_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_rr    <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_slice_g = '0;
        w_slice_r = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_slice_g = ledg_in[i*LED_W +: LED_W];
                w_slice_r = ledr_in[i*LED_W +: LED_W];
            end
        end
    end

    // Pin k carries bit k of the owner's slice.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            pmodledg <= '0;
            pmodledr <= '0;
        end else begin
            for (int k = 0; k < LED_W; k++) begin
                pmodledg[k] <= (r_state == GRANT) ? w_slice_g[k] : 1'b0;
                pmodledr[k] <= (r_state == GRANT) ? w_slice_r[k] : 1'b0;
            end
        end
    end

    assign grant = (r_state == GRANT) ? w_owner_oh : '0;
    assign busy  = (r_state != IDLE);

endmodule
